// File: rtl/piece_spawn_if.sv
// Handshake bundle between the piece-spawn controller and its neighbours: game FSM
// commands in, queue head in, queue advance and falling/hold piece state out.
interface piece_spawn_if;
  logic       start;
  logic       clear;
  logic       lock_req;
  logic       hold_req;
  logic [3:0] queue_head;
  logic       pieces_remove;
  logic [3:0] falling_type;
  logic       falling_valid;
  logic       spawn_pulse;
  logic [3:0] held_type;
  logic       hold_used;

  // Queue handshake: queue_head != BLANK is "valid"; pieces_remove is the one-cycle
  // "ready" that consumes it, and it is raised only in the cycle the head is taken.
  modport master (
    output start, clear, lock_req, hold_req, queue_head,
    input  pieces_remove, falling_type, falling_valid, spawn_pulse, held_type, hold_used
  );

  modport slave (
    input  start, clear, lock_req, hold_req, queue_head,
    output pieces_remove, falling_type, falling_valid, spawn_pulse, held_type, hold_used
  );
endinterface

// File: rtl/piece_spawn_ctrl.sv
// Decides when the falling tetromino is taken from the next-pieces queue, applies the
// entry delay after lock, and owns the hold slot with its once-per-piece rule.
module piece_spawn_ctrl #(
  parameter int ENTRY_DELAY = 4,
  parameter int HOLD_ENABLE = 1
) (
  input  logic          clk,
  input  logic          rst_l,
  piece_spawn_if.slave  bus,
  output logic [1:0]    state_o
);

  localparam logic [3:0] BLANK = 4'd0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_FETCH  = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  localparam int CNT_W = (ENTRY_DELAY > 0) ? $clog2(ENTRY_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (ENTRY_DELAY > 0) ? CNT_W'(ENTRY_DELAY - 1) : '0;
  localparam logic [1:0] S_AFTER_LOCK = (ENTRY_DELAY > 0) ? S_DELAY : S_FETCH;
  localparam logic HOLD_ON = (HOLD_ENABLE != 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             from_hold_q, from_hold_d;
  logic [3:0]       falling_type_q, falling_type_d;
  logic             falling_valid_q, falling_valid_d;
  logic             spawn_q, spawn_d;
  logic [3:0]       held_type_q, held_type_d;
  logic             hold_used_q, hold_used_d;
  logic             head_valid;
  logic             hold_ok;

  assign head_valid = (bus.queue_head != BLANK);
  assign hold_ok    = HOLD_ON && bus.hold_req && !hold_used_q;

  // Remove is tied to the exact cycle the head is latched, so the queue can only
  // advance once per visit to FETCH; clear suppresses it.
  assign bus.pieces_remove = (state_q == S_FETCH) && head_valid && !bus.clear;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    from_hold_d     = from_hold_q;
    falling_type_d  = falling_type_q;
    falling_valid_d = falling_valid_q;
    spawn_d         = 1'b0;
    held_type_d     = held_type_q;
    hold_used_d     = hold_used_q;

    if (bus.clear) begin
      state_d         = S_IDLE;
      cnt_d           = '0;
      from_hold_d     = 1'b0;
      falling_type_d  = BLANK;
      falling_valid_d = 1'b0;
      held_type_d     = BLANK;
      hold_used_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_AFTER_LOCK;
            cnt_d   = CNT_INIT;
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) state_d = S_FETCH;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_FETCH: begin
          if (head_valid) begin
            falling_type_d  = bus.queue_head;
            falling_valid_d = 1'b1;
            spawn_d         = 1'b1;
            hold_used_d     = from_hold_q;
            from_hold_d     = 1'b0;
            state_d         = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (bus.lock_req) begin
            falling_valid_d = 1'b0;
            falling_type_d  = BLANK;
            state_d         = S_AFTER_LOCK;
            cnt_d           = CNT_INIT;
          end else if (hold_ok) begin
            if (held_type_q == BLANK) begin
              // Empty hold: stash the piece and fetch a fresh one with no entry delay.
              held_type_d     = falling_type_q;
              falling_valid_d = 1'b0;
              falling_type_d  = BLANK;
              from_hold_d     = 1'b1;
              state_d         = S_FETCH;
            end else begin
              held_type_d    = falling_type_q;
              falling_type_d = held_type_q;
              hold_used_d    = 1'b1;
              spawn_d        = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      from_hold_q     <= 1'b0;
      falling_type_q  <= BLANK;
      falling_valid_q <= 1'b0;
      spawn_q         <= 1'b0;
      held_type_q     <= BLANK;
      hold_used_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      from_hold_q     <= from_hold_d;
      falling_type_q  <= falling_type_d;
      falling_valid_q <= falling_valid_d;
      spawn_q         <= spawn_d;
      held_type_q     <= held_type_d;
      hold_used_q     <= hold_used_d;
    end
  end

  assign bus.falling_type  = falling_type_q;
  assign bus.falling_valid = falling_valid_q;
  assign bus.spawn_pulse   = spawn_q;
  assign bus.held_type     = held_type_q;
  assign bus.hold_used     = hold_used_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_piece_spawn_ctrl.sv
// Directed bench for piece_spawn_ctrl (ENTRY_DELAY=4, HOLD_ENABLE=1) with
// hand-computed expectations checked by immediate assertions.
module tb_piece_spawn_ctrl;

  localparam logic [3:0] BLANK = 4'd0;
  localparam logic [3:0] P_I = 4'd1, P_O = 4'd2, P_T = 4'd3, P_S = 4'd4;
  localparam logic [3:0] P_Z = 4'd5, P_J = 4'd6, P_L = 4'd7;
  localparam logic [1:0] S_IDLE = 2'd0, S_DELAY = 2'd1, S_FETCH = 2'd2, S_ACTIVE = 2'd3;

  logic       clk;
  logic       rst_l;
  logic [1:0] state;
  int         vectors;
  int         miscompares;

  piece_spawn_if bus ();

  piece_spawn_ctrl #(.ENTRY_DELAY(4), .HOLD_ENABLE(1)) dut (
    .clk     (clk),
    .rst_l   (rst_l),
    .bus     (bus.slave),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"},  8'(state), 8'(S_IDLE));
    chk({tag, "_remove"}, 8'(bus.pieces_remove), 8'd0);
    chk({tag, "_ftype"},  8'(bus.falling_type), 8'(BLANK));
    chk({tag, "_fvalid"}, 8'(bus.falling_valid), 8'd0);
    chk({tag, "_spawn"},  8'(bus.spawn_pulse), 8'd0);
    chk({tag, "_held"},   8'(bus.held_type), 8'(BLANK));
    chk({tag, "_hused"},  8'(bus.hold_used), 8'd0);
  endtask

  // Lock the active piece, ride out the 4-cycle entry delay, fetch head_val.
  task automatic lock_and_fetch(input logic [3:0] head_val, input string tag);
    bus.queue_head = head_val;
    bus.lock_req = 1'b1;
    step();
    bus.lock_req = 1'b0;
    chk({tag, "_delay"}, 8'(state), 8'(S_DELAY));
    repeat (4) step();
    #1;
    chk({tag, "_remove"}, 8'(bus.pieces_remove), 8'd1);
    step();
    chk({tag, "_ftype"}, 8'(bus.falling_type), 8'(head_val));
    chk({tag, "_spawn"}, 8'(bus.spawn_pulse), 8'd1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_l = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.lock_req = 1'b0;
    bus.hold_req = 1'b0;
    bus.queue_head = BLANK;
    repeat (2) step();
    chk_idle_outputs("reset");
    rst_l = 1'b1;
    step();
    bus.lock_req = 1'b1;
    step();
    bus.lock_req = 1'b0;
    chk("lock_in_idle_ignored", 8'(state), 8'(S_IDLE));

    // 1: start at c0 with head T, remove only at c5, spawn at c6
    bus.queue_head = P_T;
    bus.start = 1'b1;
    #1;
    chk("t1_remove_c0", 8'(bus.pieces_remove), 8'd0);
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t1_remove_c%0d", c), 8'(bus.pieces_remove), 8'd0);
      step();
    end
    chk("t1_remove_c5", 8'(bus.pieces_remove), 8'd1);
    chk("t1_state_c5", 8'(state), 8'(S_FETCH));
    step();
    chk("t1_remove_c6", 8'(bus.pieces_remove), 8'd0);
    chk("t1_ftype", 8'(bus.falling_type), 8'(P_T));
    chk("t1_fvalid", 8'(bus.falling_valid), 8'd1);
    chk("t1_spawn", 8'(bus.spawn_pulse), 8'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t1_spawn_c7", 8'(bus.spawn_pulse), 8'd0);
    chk("t1_start_ignored", 8'(state), 8'(S_ACTIVE));

    // 5: lock and hold together, lock wins
    bus.queue_head = BLANK;
    bus.lock_req = 1'b1;
    bus.hold_req = 1'b1;
    step();
    bus.lock_req = 1'b0;
    bus.hold_req = 1'b0;
    chk("t5_state", 8'(state), 8'(S_DELAY));
    chk("t5_held", 8'(bus.held_type), 8'(BLANK));
    chk("t5_fvalid", 8'(bus.falling_valid), 8'd0);
    chk("t5_ftype", 8'(bus.falling_type), 8'(BLANK));

    // 2: head BLANK for 10 cycles in FETCH, then I appears
    repeat (4) step();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t2_wait_%0d", c), 8'(bus.pieces_remove), 8'd0);
      step();
    end
    chk("t2_state_wait", 8'(state), 8'(S_FETCH));
    bus.queue_head = P_I;
    #1;
    chk("t2_remove", 8'(bus.pieces_remove), 8'd1);
    step();
    chk("t2_remove_after", 8'(bus.pieces_remove), 8'd0);
    chk("t2_ftype", 8'(bus.falling_type), 8'(P_I));
    chk("t2_spawn", 8'(bus.spawn_pulse), 8'd1);
    chk("t5_hused_next", 8'(bus.hold_used), 8'd0);

    // 3: active L, empty hold, hold -> fetch S at once
    lock_and_fetch(P_L, "t3_fetchL");
    bus.queue_head = P_S;
    bus.hold_req = 1'b1;
    step();
    bus.hold_req = 1'b0;
    chk("t3_held", 8'(bus.held_type), 8'(P_L));
    chk("t3_fvalid", 8'(bus.falling_valid), 8'd0);
    chk("t3_state", 8'(state), 8'(S_FETCH));
    chk("t3_remove", 8'(bus.pieces_remove), 8'd1);
    step();
    chk("t3_ftype", 8'(bus.falling_type), 8'(P_S));
    chk("t3_spawn", 8'(bus.spawn_pulse), 8'd1);
    chk("t3_hused", 8'(bus.hold_used), 8'd1);
    bus.hold_req = 1'b1;
    step();
    bus.hold_req = 1'b0;
    chk("t3_2nd_ftype", 8'(bus.falling_type), 8'(P_S));
    chk("t3_2nd_held", 8'(bus.held_type), 8'(P_L));
    chk("t3_2nd_spawn", 8'(bus.spawn_pulse), 8'd0);

    // 4: set up active Z / held O / hold_used 0, then swap
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk_idle_outputs("clear_active");
    bus.queue_head = P_O;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    chk("t4_ftypeO", 8'(bus.falling_type), 8'(P_O));
    bus.queue_head = P_Z;
    bus.hold_req = 1'b1;
    step();
    bus.hold_req = 1'b0;
    step();
    chk("t4_ftypeZ", 8'(bus.falling_type), 8'(P_Z));
    lock_and_fetch(P_Z, "t4_fetchZ");
    chk("t4_pre_held", 8'(bus.held_type), 8'(P_O));
    chk("t4_pre_hused", 8'(bus.hold_used), 8'd0);
    step();
    bus.hold_req = 1'b1;
    #1;
    chk("t4_remove_req", 8'(bus.pieces_remove), 8'd0);
    step();
    bus.hold_req = 1'b0;
    chk("t4_ftype", 8'(bus.falling_type), 8'(P_O));
    chk("t4_held", 8'(bus.held_type), 8'(P_Z));
    chk("t4_hused", 8'(bus.hold_used), 8'd1);
    chk("t4_spawn", 8'(bus.spawn_pulse), 8'd1);
    chk("t4_fvalid", 8'(bus.falling_valid), 8'd1);
    chk("t4_remove", 8'(bus.pieces_remove), 8'd0);

    // 6a: clear in FETCH with a valid head
    bus.queue_head = BLANK;
    bus.lock_req = 1'b1;
    step();
    bus.lock_req = 1'b0;
    repeat (4) step();
    chk("t6_state_fetch", 8'(state), 8'(S_FETCH));
    bus.queue_head = P_J;
    bus.clear = 1'b1;
    #1;
    chk("t6_remove_clear", 8'(bus.pieces_remove), 8'd0);
    step();
    bus.clear = 1'b0;
    chk_idle_outputs("t6_clear");

    // 6b: asynchronous reset mid-DELAY
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("t6_state_delay", 8'(state), 8'(S_DELAY));
    #2;
    rst_l = 1'b0;
    #1;
    chk_idle_outputs("t6_rst");
    step();
    rst_l = 1'b1;
    repeat (6) begin
      chk("t6_rst_no_remove", 8'(bus.pieces_remove), 8'd0);
      step();
    end
    chk("t6_rst_idle", 8'(state), 8'(S_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
